uart_tx_serializer: RTL and testbench

- Transmit-side endpoint for the byte stream produced by the display-string logic (tx_data_rdy / tx_data strobe pairs).
- Buffers bytes in a small FIFO and serializes each one onto the UART TX pin as 8N1 (1 start, 8 data LSB-first, 1 stop).
- It is the counterpart of the receive path that feeds rx_data / rx_data_rdy into the lab top level.
- The producer has no flow control, so the FIFO absorbs bursts. An 8-byte status line per second fits easily.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_serializer_byte_fifo.sv | 63 ++++++
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and default timing constants for the UART transmit path.
// Baud divisor defaults assume a 12 MHz core clock driving a 115200 baud line.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int CLK_HZ           = 12000000;
    localparam int BAUD             = 115200;
    localparam int BAUD_DIV_DEFAULT = 104;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_byte_fifo.sv
// Synchronous byte FIFO; head visible combinationally on dout, count updates the edge after push/pop.
// No backpressure: a push while full is ignored unless a pop happens on the same edge.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers strobed bytes and shifts them out as 8N1 frames; line falls one edge after the byte is queued.
// Producer has no flow control: bytes strobed into a full FIFO without a same-edge pop are dropped and flagged.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_data_rdy,
    input  logic [7:0]                    tx_data,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    logic [1:0]    r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_overflow;

    logic [7:0]    w_fifo_dout;
    logic [LW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_baud_last;
    logic          w_pop;

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);
    // Pop only when a frame is about to start: from IDLE, or at the last stop cycle for back-to-back frames.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_data_rdy),
        .pop   (w_pop),
        .din   (tx_data),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // r_tx is loaded with the level of the state being entered, so the pin never passes through logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (tx_data_rdy && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign uart_tx    = r_tx;
    assign tx_busy    = (w_fifo_count != '0) || (r_state != S_IDLE);
    assign fifo_full  = w_fifo_full;
    assign fifo_level = w_fifo_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (16-deep and 4-deep FIFO, 4 clocks per bit)
// checked every cycle against a frame-schedule model, plus directed frame and corner sequences.
module tb_uart_tx_serializer;

    localparam int B  = 4;
    localparam int TR = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] dat_a = 8'h00, dat_b = 8'h00;
    logic       line_a, busy_a, full_a, ovf_a;
    logic       line_b, busy_b, full_b, ovf_b;
    logic [4:0] lvl_a;
    logic [2:0] lvl_b;

    uart_tx_serializer #(.BAUD_DIV(B), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .tx_data_rdy(rdy_a), .tx_data(dat_a),
        .uart_tx(line_a), .tx_busy(busy_a), .fifo_full(full_a),
        .fifo_level(lvl_a), .overflow(ovf_a)
    );

    uart_tx_serializer #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .tx_data_rdy(rdy_b), .tx_data(dat_b),
        .uart_tx(line_b), .tx_busy(busy_b), .fifo_full(full_b),
        .fifo_level(lvl_b), .overflow(ovf_b)
    );

    typedef struct packed {
        logic       line;
        logic       busy;
        logic       full;
        logic [4:0] lvl;
        logic       ovf;
    } obs_t;

    typedef struct {
        logic [7:0] dat;
        logic [9:0] bits;   // bit i = line level during the i-th bit period
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: every accepted byte with the edge at which its frame starts.
    int         m_start [2][64];
    logic [7:0] m_data  [2][64];
    int         m_n     [2] = '{0, 0};
    logic       m_ovf   [2] = '{1'b0, 1'b0};

    logic       tr_line [2][TR];
    logic       tr_busy [2][TR];
    int         tr_lvl  [2][TR];
    logic [7:0] rx_got  [16];

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic model_edge(input int k, input logic r, input logic v,
                              input logic [7:0] d, input int e);
        int w, cnt, s, last_end;
        logic popn;
        if (!r) begin
            m_n[k]   = 0;
            m_ovf[k] = 1'b0;
            return;
        end
        w = 0;
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_start[k][i] + 10 * B > e) begin
                m_start[k][w] = m_start[k][i];
                m_data[k][w]  = m_data[k][i];
                w++;
            end
        end
        m_n[k] = w;
        cnt  = 0;
        popn = 1'b0;
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_start[k][i] >= e) cnt++;
            if (m_start[k][i] == e) popn = 1'b1;
        end
        if (v) begin
            if (cnt < depth_of(k) || popn) begin
                last_end = (m_n[k] > 0) ? m_start[k][m_n[k]-1] + 10 * B : 0;
                s = (e + 1 > last_end) ? e + 1 : last_end;
                m_start[k][m_n[k]] = s;
                m_data[k][m_n[k]]  = d;
                m_n[k]++;
            end else begin
                m_ovf[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, rst_a, rdy_a, dat_a, cyc);
        model_edge(1, rst_b, rdy_b, dat_b, cyc);
        cyc <= cyc + 1;
    end

    function automatic obs_t model_obs(input int k, input int t);
        obs_t o;
        int lvl, s, j;
        lvl    = 0;
        o.line = 1'b1;
        o.busy = 1'b0;
        for (int i = 0; i < m_n[k]; i++) begin
            s = m_start[k][i];
            if (s > t) begin
                lvl++;
            end else if (t < s + 10 * B) begin
                j = (t - s) / B;
                o.busy = 1'b1;
                if (j == 0)      o.line = 1'b0;
                else if (j == 9) o.line = 1'b1;
                else             o.line = m_data[k][i][j-1];
            end
        end
        if (lvl != 0) o.busy = 1'b1;
        o.lvl  = 5'(lvl);
        o.full = (lvl == depth_of(k));
        o.ovf  = m_ovf[k];
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        obs_t a, b;
        int t;
        @(negedge clk);
        t = cyc - 1;
        a = {line_a, busy_a, full_a, lvl_a, ovf_a};
        b = {line_b, busy_b, full_b, {2'b00, lvl_b}, ovf_b};
        chk("model_a", 32'(a), 32'(model_obs(0, t)));
        chk("model_b", 32'(b), 32'(model_obs(1, t)));
        tr_line[0][t % TR] = line_a;
        tr_busy[0][t % TR] = busy_a;
        tr_lvl[0][t % TR]  = int'(lvl_a);
        tr_line[1][t % TR] = line_b;
        tr_busy[1][t % TR] = busy_b;
        tr_lvl[1][t % TR]  = int'(lvl_b);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while (n < budget && ((k == 0) ? busy_a : busy_b)) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'((k == 0) ? busy_a : busy_b), 32'd0);
    endtask

    // Receiver: find the first falling edge after t0, then sample mid-bit of n contiguous frames.
    task automatic decode(input int k, input int t0, input int n, output int s0);
        logic v;
        int base;
        s0 = -1;
        for (int t = t0; t < t0 + 200 && s0 < 0; t++) begin
            if (tr_line[k][t % TR] == 1'b0 && tr_line[k][(t - 1) % TR] == 1'b1) s0 = t;
        end
        chk("rx_start_found", 32'(s0 >= 0), 32'd1);
        if (s0 < 0) s0 = t0;
        for (int f = 0; f < 16; f++) rx_got[f] = 8'h00;
        for (int f = 0; f < n; f++) begin
            base = s0 + 10 * B * f;
            for (int j = 0; j < 10; j++) begin
                v = tr_line[k][(base + j * B + B / 2) % TR];
                if (j == 0)      chk("rx_start_bit", 32'(v), 32'd0);
                else if (j == 9) chk("rx_stop_bit", 32'(v), 32'd1);
                else             rx_got[f][j-1] = v;
            end
        end
    endtask

    function automatic int first_idle(input int k, input int from, input int lim);
        for (int t = from; t < from + lim; t++) begin
            if (tr_busy[k][t % TR] == 1'b0) return t;
        end
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [6];
        logic [7:0] burst [8];
        logic [9:0] cap;
        int         n0, s0, peak;

        vt[0] = '{8'hA5, 10'b1101001010};
        vt[1] = '{8'h00, 10'b1000000000};
        vt[2] = '{8'hFF, 10'b1111111110};
        vt[3] = '{8'h3C, 10'b1001111000};
        vt[4] = '{8'h0D, 10'b1000011010};
        vt[5] = '{8'h55, 10'b1010101010};
        burst = '{8'h41, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h40, 8'h0D};

        // Reset held with strobes active.
        rdy_a = 1'b1; rdy_b = 1'b1; dat_a = 8'hFF; dat_b = 8'hFF;
        repeat (5) tick();
        chk("rst_line_a", 32'(line_a), 32'd1);
        chk("rst_level_a", 32'(lvl_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_line_b", 32'(line_b), 32'd1);
        chk("rst_full_b", 32'(full_b), 32'd0);
        rdy_a = 1'b0; rdy_b = 1'b0;
        tick();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (4) tick();
        chk("idle_line_a", 32'(line_a), 32'd1);
        chk("idle_busy_a", 32'(busy_a), 32'd0);

        // Single frames from the table.
        for (int i = 0; i < 6; i++) begin
            dat_a = vt[i].dat; rdy_a = 1'b1;
            n0 = cyc;
            tick();
            rdy_a = 1'b0;
            chk("pre_fall", 32'(line_a), 32'd1);
            tick();
            chk("fall_1cyc", 32'(line_a), 32'd0);
            repeat (39) tick();
            chk("busy_last_cycle", 32'(busy_a), 32'd1);
            tick();
            chk("busy_drop_40", 32'(busy_a), 32'd0);
            for (int j = 0; j < 10; j++) cap[j] = tr_line[0][(n0 + 1 + j * B + B / 2) % TR];
            chk($sformatf("frame_bits_%02h", vt[i].dat), 32'(cap), 32'(vt[i].bits));
            tick();
        end

        // Burst of 8 consecutive strobes.
        n0 = cyc;
        for (int i = 0; i < 8; i++) begin
            dat_a = burst[i]; rdy_a = 1'b1;
            tick();
        end
        rdy_a = 1'b0;
        wait_idle(0, 600);
        decode(0, n0, 8, s0);
        chk("burst_first_start", 32'(s0), 32'(n0 + 1));
        for (int i = 0; i < 8; i++) chk($sformatf("burst_byte%0d", i), 32'(rx_got[i]), 32'(burst[i]));
        chk("burst_total_cycles", 32'(first_idle(0, s0, 600) - s0), 32'd320);
        peak = 0;
        for (int t = n0; t < n0 + 330; t++) if (tr_lvl[0][t % TR] > peak) peak = tr_lvl[0][t % TR];
        chk("burst_peak_level", 32'(peak), 32'd7);

        // Depth 4: fill, then strobe on the stop->start pop edge.
        n0 = cyc;
        for (int i = 0; i < 5; i++) begin
            dat_b = 8'h20 + 8'(i); rdy_b = 1'b1;
            tick();
        end
        rdy_b = 1'b0;
        chk("fill_full", 32'(full_b), 32'd1);
        chk("fill_level", 32'(lvl_b), 32'd4);
        repeat (36) tick();
        chk("popcyc_level_before", 32'(lvl_b), 32'd4);
        chk("popcyc_stop_bit", 32'(line_b), 32'd1);
        dat_b = 8'h25; rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        chk("popcyc_level_after", 32'(lvl_b), 32'd4);
        chk("popcyc_no_ovf", 32'(ovf_b), 32'd0);
        chk("popcyc_next_start", 32'(line_b), 32'd0);
        wait_idle(1, 400);
        decode(1, n0, 6, s0);
        for (int i = 0; i < 6; i++) chk($sformatf("popcyc_byte%0d", i), 32'(rx_got[i]), 32'h20 + 32'(i));

        // Depth 4: overflow on the sixth strobe.
        n0 = cyc;
        for (int i = 0; i < 6; i++) begin
            dat_b = 8'h10 + 8'(i); rdy_b = 1'b1;
            tick();
        end
        rdy_b = 1'b0;
        chk("ovf_set", 32'(ovf_b), 32'd1);
        chk("ovf_full", 32'(full_b), 32'd1);
        wait_idle(1, 400);
        decode(1, n0, 5, s0);
        for (int i = 0; i < 5; i++) chk($sformatf("ovf_byte%0d", i), 32'(rx_got[i]), 32'h10 + 32'(i));
        chk("ovf_five_frames_only", 32'(first_idle(1, s0, 400) - s0), 32'd200);

        // Reset during data bit 3.
        n0 = cyc;
        dat_a = 8'h52; rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        repeat (18) tick();
        chk("midframe_bit3_low", 32'(line_a), 32'd0);
        #1 rst_a = 1'b0;
        #1;
        chk("midframe_rst_line", 32'(line_a), 32'd1);
        chk("midframe_rst_busy", 32'(busy_a), 32'd0);
        chk("midframe_rst_level", 32'(lvl_a), 32'd0);
        repeat (2) tick();
        rst_a = 1'b1;
        repeat (3) tick();
        chk("after_rst_idle", 32'(line_a), 32'd1);
        n0 = cyc;
        dat_a = 8'h3C; rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        wait_idle(0, 100);
        decode(0, n0, 1, s0);
        chk("after_rst_start", 32'(s0), 32'(n0 + 1));
        chk("after_rst_byte", 32'(rx_got[0]), 32'h3C);

        // Random traffic at three strobe densities.
        for (int p = 0; p < 3; p++) begin
            int lim;
            lim = (p == 0) ? 60 : ((p == 1) ? 20 : 3);
            repeat (1500) begin
                rdy_a = ($urandom_range(0, lim) == 0);
                dat_a = 8'($urandom);
                rdy_b = ($urandom_range(0, lim) == 0);
                dat_b = 8'($urandom);
                tick();
            end
            rdy_a = 1'b0; rdy_b = 1'b0;
            wait_idle(0, 1000);
            wait_idle(1, 400);
        end

        chk("ovf_sticky_end", 32'(ovf_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
